xbus_fb_ctl: RTL and testbench

//  Parametrised Xbus framebuffer slave, next generation of the b&w TV block. Decodes NPLANES

---
 rtl/xbus_fb_pkg.sv | 35 +++
 rtl/xbus_fb_frame_timer.sv | 38 +++
 rtl/xbus_fb_ctl.sv | 191 +++++++++++++++++++
 tb/tb_xbus_fb_ctl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_fb_pkg.sv
// Shared definitions for the Xbus framebuffer slave.
//   - state_e          : bus-side FSM states
//   - REG_*            : register indices within the 8-word register bank
//   - CTRL_*           : bit positions inside the CTRL register
//   - ERR_READ_VAL     : data returned by a read that timed out waiting for VRAM
//   - COLOR_PROBE_ADDR : legacy colour-probe address, aliased to plane 1 on multi-plane builds
//   - plane_width()    : width of the plane-index field of the VRAM address
package xbus_fb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_REG,
      ST_DONE
   } state_e;

   localparam logic [2:0] REG_CTRL  = 3'd0;
   localparam logic [2:0] REG_FRAME = 3'd1;
   localparam logic [2:0] REG_GEOM  = 3'd2;

   localparam int CTRL_INT_EN   = 3;
   localparam int CTRL_INT_FLAG = 4;
   localparam int CTRL_ERR      = 5;

   localparam logic [31:0] ERR_READ_VAL     = 32'hFFFF_FFFF;
   localparam logic [21:0] COLOR_PROBE_ADDR = 22'o17200000;

   // A single-plane build still carries one plane bit so the VRAM address
   // layout stays the same across configurations.
   function automatic int plane_width(input int nplanes);
      return (nplanes > 1) ? $clog2(nplanes) : 1;
   endfunction

endpackage

// File: rtl/xbus_fb_frame_timer.sv
// Vertical-frame timer: divides clk down to the frame rate.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   frame_tick out  one-cycle pulse on the cycle the divider wraps
//   frame_cnt  out  16-bit count of completed frames, wraps 16'hFFFF -> 0
module xbus_fb_frame_timer #(
   parameter int unsigned DIV = 833333
) (
   input  logic        clk,
   input  logic        reset,
   output logic        frame_tick,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] div_cnt;

   // Combinational so the owner of int_flag sees the wrap on the same edge
   // the divider returns to zero.
   assign frame_tick = (div_cnt == CNT_W'(DIV - 1));

   // NOTE: sequential state is assigned with <= only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         frame_cnt <= '0;
      end else if (frame_tick) begin
         div_cnt   <= '0;
         frame_cnt <= frame_cnt + 16'd1;
      end else begin
         div_cnt   <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/xbus_fb_ctl.sv
// Xbus framebuffer slave. Decodes NPLANES VRAM windows and an 8-word register
// bank, forwards plane accesses to the VRAM port with a bounded wait, and
// raises a frame-rate interrupt.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   addr, datain   Xbus request address / write data
//   req, write     request (held until ack) and direction (1 = write)
//   dataout, ack   read data (valid while ack) and completion
//   decode         combinational: addr hits a plane window or the register bank
//   interrupt      int_en & int_flag
//   vram_addr      {plane, word offset}, captured when the access starts
//   vram_data_out  write data to VRAM (= datain)
//   vram_data_in   read data from VRAM, valid with vram_ready
//   vram_req       read strobe, held until vram_ready or timeout
//   vram_ready     read data valid
//   vram_write     write strobe, held until vram_done or timeout
//   vram_done      write accepted
module xbus_fb_ctl
   import xbus_fb_pkg::*;
#(
   parameter logic [21:0] FB_BASE  = 22'o17000000,
   parameter logic [21:0] REG_BASE = 22'o17377760,
   parameter int          ADDR_W   = 15,
   parameter int          NPLANES  = 1,
   parameter int          SYS_CLK  = 50000000,
   parameter int          FRAME_HZ = 60,
   parameter int          TIMEOUT  = 255,
   localparam int         PLANE_W  = plane_width(NPLANES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [21:0]                addr,
   input  logic [31:0]                datain,
   input  logic                       req,
   input  logic                       write,
   output logic [31:0]                dataout,
   output logic                       ack,
   output logic                       decode,
   output logic                       interrupt,
   output logic [ADDR_W+PLANE_W-1:0]  vram_addr,
   output logic [31:0]                vram_data_out,
   input  logic [31:0]                vram_data_in,
   output logic                       vram_req,
   input  logic                       vram_ready,
   output logic                       vram_write,
   input  logic                       vram_done
);

   localparam int DIV    = (SYS_CLK / FRAME_HZ > 0) ? SYS_CLK / FRAME_HZ : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_expired;
   logic                int_en, int_flag, err;
   logic                frame_tick;
   logic [15:0]         frame_cnt;
   logic [21:0]         fb_off, fb_plane;
   logic                plane_hit, probe_hit, reg_hit;
   logic [PLANE_W-1:0]  hit_plane;
   logic [ADDR_W-1:0]   hit_off;
   logic [31:0]         reg_rdata;

   xbus_fb_frame_timer #(
      .DIV (DIV)
   ) u_frame_timer (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .frame_cnt  (frame_cnt)
   );

   // Address decode. A plane index at or beyond NPLANES is left undecoded so
   // the bus master times out rather than getting a bogus ack.
   always_comb begin : addr_decode
      fb_off    = addr - FB_BASE;
      fb_plane  = fb_off >> ADDR_W;
      probe_hit = (NPLANES > 1) && (addr == COLOR_PROBE_ADDR);
      reg_hit   = (addr[21:3] == REG_BASE[21:3]);
      plane_hit = probe_hit || ((addr >= FB_BASE) && (fb_plane < 22'(NPLANES)));
      hit_plane = probe_hit ? PLANE_W'(1) : fb_plane[PLANE_W-1:0];
      hit_off   = probe_hit ? '0 : fb_off[ADDR_W-1:0];
   end

   assign decode        = plane_hit || reg_hit;
   assign interrupt     = int_en & int_flag;
   assign vram_data_out = datain;
   assign wait_expired  = (wait_cnt == WAIT_W'(TIMEOUT - 1));

   always_comb begin : reg_read_mux
      reg_rdata = '0;
      case (addr[2:0])
         REG_CTRL: begin
            reg_rdata[CTRL_INT_EN]   = int_en;
            reg_rdata[CTRL_INT_FLAG] = int_flag;
            reg_rdata[CTRL_ERR]      = err;
         end
         REG_FRAME: reg_rdata = {16'b0, frame_cnt};
         REG_GEOM:  reg_rdata = {8'(NPLANES), 3'b0, 5'(ADDR_W), 16'b0};
         default:   reg_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin : fsm_state
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin : fsm_next
      state_d    = state_q;
      ack        = 1'b0;
      vram_req   = 1'b0;
      vram_write = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && reg_hit)        state_d = ST_REG;
            else if (req && plane_hit) state_d = write ? ST_WRITE : ST_READ;
         end
         ST_READ: begin
            vram_req = 1'b1;
            if (vram_ready || wait_expired) state_d = ST_DONE;
         end
         ST_WRITE: begin
            vram_write = 1'b1;
            if (vram_done || wait_expired) state_d = ST_DONE;
         end
         ST_REG:  state_d = ST_DONE;
         // Leaving DONE only on a dropped req keeps a held req from
         // starting a second access.
         ST_DONE: begin
            ack = 1'b1;
            if (!req) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : datapath
      if (reset) begin
         dataout   <= '0;
         int_en    <= 1'b0;
         int_flag  <= 1'b0;
         err       <= 1'b0;
         wait_cnt  <= '0;
         vram_addr <= '0;
      end else begin
         case (state_q)
            // Address is captured every idle cycle so it is stable for the
            // whole access; the wait counter restarts for each access.
            ST_IDLE: begin
               wait_cnt  <= '0;
               vram_addr <= {hit_plane, hit_off};
            end
            ST_READ: begin
               if (vram_ready) begin
                  dataout <= vram_data_in;
               end else if (wait_expired) begin
                  dataout <= ERR_READ_VAL;
                  err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_WRITE: begin
               if (!vram_done) begin
                  if (wait_expired) err <= 1'b1;
                  else              wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_REG: begin
               if (write) begin
                  if (addr[2:0] == REG_CTRL) begin
                     int_en <= datain[CTRL_INT_EN];
                     if (datain[CTRL_INT_FLAG]) int_flag <= 1'b0;
                     if (datain[CTRL_ERR])      err      <= 1'b0;
                  end
               end else begin
                  dataout <= reg_rdata;
               end
            end
            default: ;
         endcase
         // NOTE: the later non-blocking assignment wins, so a frame wrap on
         // the same edge as a write-1-to-clear leaves int_flag set.
         if (frame_tick) int_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_xbus_fb_ctl.sv
// Self-checking bench for xbus_fb_ctl (NPLANES=2, 10-cycle frame, 16-cycle timeout).
// Expected values come from a cycle-count model of the frame timer and
// simple scalar models of int_en / err / int_flag clear time.
module tb_xbus_fb_ctl;

   localparam logic [21:0] FB_BASE  = 22'o17000000;
   localparam logic [21:0] REG_BASE = 22'o17377760;
   localparam logic [21:0] PROBE    = 22'o17200000;
   localparam int ADDR_W   = 15;
   localparam int NPLANES  = 2;
   localparam int SYS_CLK  = 600;
   localparam int FRAME_HZ = 60;
   localparam int TIMEOUT  = 16;
   localparam int DIV      = SYS_CLK / FRAME_HZ;
   localparam int VA_W     = ADDR_W + 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [21:0]     addr = '0;
   logic [31:0]     datain = '0;
   logic            req = 1'b0;
   logic            write = 1'b0;
   logic [31:0]     dataout;
   logic            ack, decode, interrupt;
   logic [VA_W-1:0] vram_addr;
   logic [31:0]     vram_data_out;
   logic [31:0]     vram_data_in = '0;
   logic            vram_req;
   logic            vram_ready = 1'b0;
   logic            vram_write;
   logic            vram_done = 1'b0;

   int total = 0;
   int bad   = 0;

   // Model state
   int n_edges = 0;      // clock edges since reset was released
   int clear_edge = 0;   // edge at which int_flag was last cleared by software
   bit int_en_m = 1'b0;
   bit err_m = 1'b0;

   xbus_fb_ctl #(
      .NPLANES  (NPLANES),
      .SYS_CLK  (SYS_CLK),
      .FRAME_HZ (FRAME_HZ),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .datain        (datain),
      .req           (req),
      .write         (write),
      .dataout       (dataout),
      .ack           (ack),
      .decode        (decode),
      .interrupt     (interrupt),
      .vram_addr     (vram_addr),
      .vram_data_out (vram_data_out),
      .vram_data_in  (vram_data_in),
      .vram_req      (vram_req),
      .vram_ready    (vram_ready),
      .vram_write    (vram_write),
      .vram_done     (vram_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) n_edges <= 0;
      else       n_edges <= n_edges + 1;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Frame wraps happen every DIV edges after reset; int_flag is set by the
   // latest wrap unless software cleared it strictly after that wrap.
   function automatic bit flag_at(input int n);
      int w;
      w = (n / DIV) * DIV;
      return (w >= DIV) && (w >= clear_edge);
   endfunction

   function automatic logic [15:0] frame_at(input int n);
      return 16'((n / DIV) % 65536);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      clear_edge = 0;
      int_en_m   = 1'b0;
      err_m      = 1'b0;
   endtask

   task automatic idle_check(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) tick;
      check({tag, " interrupt"}, interrupt, int_en_m & flag_at(n_edges));
   endtask

   task automatic wait_phase(input int ph);
      int guard = 0;
      while ((n_edges % DIV) != ph && guard < 4 * DIV) begin
         tick;
         guard++;
      end
   endtask

   // Plane access with the bench acting as VRAM; dly = response cycles, 0 = silent.
   task automatic vram_access(input bit wr, input logic [21:0] a, input logic [31:0] wd,
                              input int dly, input logic [31:0] rd,
                              input logic [VA_W-1:0] exp_va, input string tag);
      int              cyc = 0;
      int              strb = 0;
      bit              got_ack = 1'b0;
      bit              wd_ok = 1'b1;
      bit              excl_ok = 1'b1;
      logic [VA_W-1:0] va_seen = '0;
      addr = a; write = wr; datain = wd; req = 1'b1;
      while (cyc < TIMEOUT + 8 && !got_ack) begin
         tick;
         cyc++;
         vram_ready = 1'b0;
         vram_done  = 1'b0;
         vram_data_in = $urandom;
         if (ack) begin
            got_ack = 1'b1;
         end else begin
            if (wr ? vram_write : vram_req) begin
               strb++;
               if (strb == 1) va_seen = vram_addr;
               if (wr && vram_data_out !== wd) wd_ok = 1'b0;
            end
            if (wr ? vram_req : vram_write) excl_ok = 1'b0;
            if (dly > 0 && strb == dly) begin
               if (wr) vram_done = 1'b1;
               else begin
                  vram_ready   = 1'b1;
                  vram_data_in = rd;
               end
            end
         end
      end
      check({tag, " ack"}, got_ack, 1);
      check({tag, " latency"}, cyc, (dly > 0) ? dly + 1 : TIMEOUT + 1);
      check({tag, " strobe cycles"}, strb, (dly > 0) ? dly : TIMEOUT);
      check({tag, " vram_addr"}, va_seen, exp_va);
      check({tag, " strobe exclusive"}, excl_ok, 1);
      check({tag, " strobes low at ack"}, vram_req | vram_write, 0);
      if (wr) check({tag, " write data"}, wd_ok, 1);
      else    check({tag, " dataout"}, dataout, (dly > 0) ? rd : 32'hFFFF_FFFF);
      if (dly == 0) err_m = 1'b1;
      req = 1'b0;
      tick;
      check({tag, " ack drop"}, ack, 0);
   endtask

   task automatic reg_access(input bit wr, input logic [2:0] idx, input logic [31:0] wd,
                             input int hold, input string tag);
      int          cyc = 0;
      bit          got = 1'b0;
      int          req_edge;
      int          n;
      logic [31:0] exp;
      addr = REG_BASE + 22'(idx); write = wr; datain = wd; req = 1'b1;
      req_edge = n_edges;
      // The register is read on edge req_edge+2, i.e. it shows the state after edge req_edge+1.
      n = req_edge + 1;
      case (idx)
         3'd0:    exp = {26'b0, err_m, flag_at(n), int_en_m, 3'b0};
         3'd1:    exp = {16'b0, frame_at(n)};
         3'd2:    exp = 32'h020F_0000;
         default: exp = 32'h0;
      endcase
      while (cyc < 8 && !got) begin
         tick;
         cyc++;
         if (ack) got = 1'b1;
      end
      check({tag, " ack"}, got, 1);
      check({tag, " latency"}, cyc, 2);
      if (!wr) check({tag, " dataout"}, dataout, exp);
      if (wr && idx == 3'd0) begin
         int_en_m = wd[3];
         if (wd[4]) clear_edge = req_edge + 2;
         if (wd[5]) err_m = 1'b0;
      end
      for (int i = 0; i < hold; i++) begin
         tick;
         check({tag, " ack held"}, ack, 1);
         check({tag, " no vram strobe"}, vram_req | vram_write, 0);
      end
      req = 1'b0;
      tick;
      check({tag, " ack drop"}, ack, 0);
   endtask

   typedef struct {
      logic [21:0] a;
      logic        exp;
   } dvec_t;

   typedef struct {
      bit              wr;
      logic [21:0]     a;
      logic [31:0]     wd;
      int              dly;
      logic [31:0]     rd;
      logic [VA_W-1:0] va;
   } tvec_t;

   dvec_t dtab[13];
   tvec_t ttab[6];

   initial begin
      dtab[0]  = '{FB_BASE,                 1'b1};
      dtab[1]  = '{FB_BASE + 22'd5,         1'b1};
      dtab[2]  = '{FB_BASE + 22'h7FFF,      1'b1};
      dtab[3]  = '{FB_BASE + 22'h8000,      1'b1};
      dtab[4]  = '{FB_BASE + 22'hFFFF,      1'b1};
      dtab[5]  = '{PROBE,                   1'b1};
      dtab[6]  = '{FB_BASE + 22'h10001,     1'b0};
      dtab[7]  = '{FB_BASE - 22'd1,         1'b0};
      dtab[8]  = '{REG_BASE,                1'b1};
      dtab[9]  = '{REG_BASE + 22'd7,        1'b1};
      dtab[10] = '{REG_BASE + 22'd8,        1'b0};
      dtab[11] = '{REG_BASE - 22'd1,        1'b0};
      dtab[12] = '{22'h0,                   1'b0};

      ttab[0] = '{1'b0, FB_BASE + 22'd5,            32'h0,         3, 32'o1234,      {1'b0, 15'd5}};
      ttab[1] = '{1'b1, FB_BASE + 22'h8000 + 22'd7, 32'hA5A5_A5A5, 2, 32'h0,         {1'b1, 15'd7}};
      ttab[2] = '{1'b0, FB_BASE + 22'h7FFF,         32'h0,         1, 32'hDEAD_BEEF, {1'b0, 15'h7FFF}};
      ttab[3] = '{1'b0, PROBE,                      32'h0,         2, 32'h1357_2468, {1'b1, 15'd0}};
      ttab[4] = '{1'b0, FB_BASE + 22'hFFFF,         32'h0,         0, 32'h0,         {1'b1, 15'h7FFF}};
      ttab[5] = '{1'b1, FB_BASE + 22'd3,            32'h1234_5678, 0, 32'h0,         {1'b0, 15'd3}};

      // Reset
      reset = 1'b1;
      tick; tick;
      reset = 1'b0;
      model_reset;
      check("reset ack", ack, 0);
      check("reset vram_req", vram_req, 0);
      check("reset vram_write", vram_write, 0);
      check("reset dataout", dataout, 0);
      check("reset interrupt", interrupt, 0);

      // Decode table
      for (int i = 0; i < 13; i++) begin
         addr = dtab[i].a;
         #1;
         check($sformatf("decode[%0d] %o", i, dtab[i].a), decode, dtab[i].exp);
      end

      reg_access(1'b0, 3'd0, 32'h0, 0, "ctrl after reset");
      reg_access(1'b0, 3'd1, 32'h0, 0, "frame early");

      // Plane access table
      for (int i = 0; i < 6; i++)
         vram_access(ttab[i].wr, ttab[i].a, ttab[i].wd, ttab[i].dly, ttab[i].rd, ttab[i].va,
                     $sformatf("xfer[%0d]", i));

      // err sticky after timeouts, write-1-to-clear
      reg_access(1'b0, 3'd0, 32'h0, 0, "ctrl err set");
      check("err bit set", dataout[5], 1);
      reg_access(1'b1, 3'd0, 32'h20, 0, "ctrl err clear");
      reg_access(1'b0, 3'd0, 32'h0, 0, "ctrl err cleared");
      check("err bit cleared", dataout[5], 0);

      // Geometry with a long-held req
      reg_access(1'b0, 3'd2, 32'h0, 5, "geom held");
      reg_access(1'b0, 3'd5, 32'h0, 0, "reg5 read");

      // Undecoded plane: no ack, no strobes
      begin
         bit seen = 1'b0;
         addr = FB_BASE + 22'h10001; write = 1'b0; req = 1'b1;
         for (int i = 0; i < TIMEOUT + 4; i++) begin
            tick;
            if (ack || vram_req || vram_write) seen = 1'b1;
         end
         check("undecoded silent", seen, 0);
         req = 1'b0;
         tick;
      end

      // Frame timer and interrupt
      idle_check(DIV + 3, "int disabled");
      reg_access(1'b1, 3'd0, 32'h08, 0, "int_en on");
      idle_check(1, "int enabled");
      wait_phase(2);
      reg_access(1'b1, 3'd0, 32'h18, 0, "clear mid-frame");
      check("flag cleared", interrupt, 0);
      wait_phase(1);
      check("flag set at wrap", interrupt, 1);
      wait_phase(DIV - 2);
      reg_access(1'b1, 3'd0, 32'h18, 0, "clear on wrap");
      check("set wins over clear", interrupt, 1);
      reg_access(1'b0, 3'd1, 32'h0, 0, "frame count");
      idle_check(2 * DIV + 4, "two frames later");
      reg_access(1'b0, 3'd1, 32'h0, 0, "frame count later");

      // Randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         int          kind;
         bit          wr;
         int          plane;
         logic [14:0] off;
         int          dly;
         logic [31:0] rd;
         kind = $urandom_range(0, 5);
         case (kind)
            0, 1: begin
               wr    = 1'($urandom_range(0, 1));
               plane = $urandom_range(0, 1);
               off   = 15'($urandom_range(0, 32767));
               dly   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
               rd    = $urandom;
               vram_access(wr, FB_BASE + 22'(plane * 32768) + 22'(off), $urandom, dly, rd,
                           {plane[0], off}, $sformatf("rand%0d vram", it));
            end
            2: reg_access(1'b0, 3'($urandom_range(0, 7)), 32'h0, $urandom_range(0, 2),
                          $sformatf("rand%0d rd", it));
            3: reg_access(1'b1, 3'd0, $urandom, 0, $sformatf("rand%0d ctrl wr", it));
            4: reg_access(1'b1, 3'($urandom_range(1, 7)), $urandom, 0,
                          $sformatf("rand%0d ro wr", it));
            default: idle_check($urandom_range(1, 12), $sformatf("rand%0d idle", it));
         endcase
      end
      reg_access(1'b0, 3'd0, 32'h0, 0, "ctrl after random");

      // Reset during a VRAM read wait
      reg_access(1'b0, 3'd2, 32'h0, 0, "geom pre-reset");
      reg_access(1'b1, 3'd0, 32'h08, 0, "int_en pre-reset");
      addr = FB_BASE + 22'd9; write = 1'b0; req = 1'b1;
      tick; tick; tick;
      check("read waiting", vram_req, 1);
      reset = 1'b1;
      req   = 1'b0;
      tick;
      check("mid reset vram_req", vram_req, 0);
      check("mid reset ack", ack, 0);
      check("mid reset dataout", dataout, 0);
      check("mid reset interrupt", interrupt, 0);
      reset = 1'b0;
      model_reset;
      tick;
      check("no ack after reset", ack, 0);
      reg_access(1'b0, 3'd0, 32'h0, 0, "ctrl post-reset");
      reg_access(1'b0, 3'd1, 32'h0, 0, "frame post-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
